// File: rtl/prsim_mon_pkg.sv
// Shared state encoding and saturating-arithmetic helpers for the prsim pulse monitor.
package prsim_mon_pkg;

   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      PEND_HI = 2'd1,
      ST_HI   = 2'd2,
      PEND_LO = 2'd3
   } state_t;

   function automatic logic [31:0] sat_max(input int unsigned width);
      return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] maxv;
      maxv = sat_max(width);
      return (value >= maxv) ? maxv : value + 32'd1;
   endfunction

   // Used when a dropout is folded back into the running high time.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned width);
      logic [32:0] sum;
      logic [31:0] maxv;
      maxv = sat_max(width);
      sum  = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, maxv}) ? maxv : sum[31:0];
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit; all stages clear on reset.
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk) begin
      if (reset) r_chain <= '0;
      else       r_chain <= {r_chain[STAGES-2:0], d};
   end

   assign q = r_chain[STAGES-1];

endmodule

// File: rtl/prsim_pulse_monitor.sv
// Synchronises and debounces a net returned from prsim, reporting edges, widths and glitches.
// Define PRSIM_MON_GLITCH_DISPLAY_EN to print a message on every rejected glitch.
module prsim_pulse_monitor
   import prsim_mon_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sig_in,
   input  logic             clear_cnt,
   output logic             filt_out,
   output logic             rise_evt,
   output logic             fall_evt,
   output logic             glitch,
   output logic [CNT_W-1:0] width,
   output logic             width_vld,
   output logic [CNT_W-1:0] glitch_cnt
);

   localparam logic [CNT_W-1:0] MIN_W_C = CNT_W'(MIN_WIDTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic             w_s;
   state_t           r_state, w_next_state;
   logic [CNT_W-1:0] r_run, w_run_nxt;
   logic [CNT_W-1:0] r_hold, w_hold_nxt;
   logic             r_filt, w_filt_nxt;
   logic             r_rise, r_fall, r_glitch, r_wvld;
   logic             w_rise, w_fall, w_glitch;
   logic [CNT_W-1:0] r_width, w_width_nxt;
   logic [CNT_W-1:0] r_gcnt, w_gcnt_nxt;

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sig_in),
      .q     (w_s)
   );

   always_comb begin
      w_next_state = r_state;
      w_run_nxt    = r_run;
      w_hold_nxt   = r_hold;
      w_filt_nxt   = r_filt;
      w_width_nxt  = r_width;
      w_rise       = 1'b0;
      w_fall       = 1'b0;
      w_glitch     = 1'b0;
      case (r_state)
         ST_LO: begin
            if (w_s) begin
               w_run_nxt = ONE_C;
               if (MIN_WIDTH == 1) begin
                  w_next_state = ST_HI;
                  w_filt_nxt   = 1'b1;
                  w_rise       = 1'b1;
               end else begin
                  w_next_state = PEND_HI;
               end
            end
         end
         PEND_HI: begin
            if (w_s) begin
               w_run_nxt = r_run + ONE_C;
               if (r_run + ONE_C == MIN_W_C) begin
                  w_next_state = ST_HI;
                  w_filt_nxt   = 1'b1;
                  w_rise       = 1'b1;
               end
            end else begin
               w_next_state = ST_LO;
               w_run_nxt    = '0;
               w_glitch     = 1'b1;
            end
         end
         ST_HI: begin
            if (w_s) begin
               w_run_nxt = CNT_W'(sat_inc(32'(r_run), CNT_W));
            end else if (MIN_WIDTH == 1) begin
               w_next_state = ST_LO;
               w_filt_nxt   = 1'b0;
               w_fall       = 1'b1;
               w_width_nxt  = r_run;
               w_run_nxt    = '0;
            end else begin
               w_next_state = PEND_LO;
               w_hold_nxt   = ONE_C;
            end
         end
         PEND_LO: begin
            if (!w_s) begin
               if (r_hold + ONE_C == MIN_W_C) begin
                  w_next_state = ST_LO;
                  w_filt_nxt   = 1'b0;
                  w_fall       = 1'b1;
                  w_width_nxt  = r_run;
                  w_run_nxt    = '0;
                  w_hold_nxt   = '0;
               end else begin
                  w_hold_nxt = r_hold + ONE_C;
               end
            end else begin
               // The dropout plus the current high sample count toward the pulse width.
               w_next_state = ST_HI;
               w_glitch     = 1'b1;
               w_run_nxt    = CNT_W'(sat_add(32'(r_run), 32'(r_hold) + 32'd1, CNT_W));
               w_hold_nxt   = '0;
            end
         end
         default: w_next_state = ST_LO;
      endcase

      if (clear_cnt)     w_gcnt_nxt = '0;
      else if (w_glitch) w_gcnt_nxt = CNT_W'(sat_inc(32'(r_gcnt), CNT_W));
      else               w_gcnt_nxt = r_gcnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_LO;
         r_run    <= '0;
         r_hold   <= '0;
         r_filt   <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_glitch <= 1'b0;
         r_wvld   <= 1'b0;
         r_width  <= '0;
         r_gcnt   <= '0;
      end else begin
         r_state  <= w_next_state;
         r_run    <= w_run_nxt;
         r_hold   <= w_hold_nxt;
         r_filt   <= w_filt_nxt;
         r_rise   <= w_rise;
         r_fall   <= w_fall;
         r_glitch <= w_glitch;
         r_wvld   <= w_fall;
         r_width  <= w_width_nxt;
         r_gcnt   <= w_gcnt_nxt;
      end
   end

`ifdef PRSIM_MON_GLITCH_DISPLAY_EN
   logic [CNT_W-1:0] w_pending;
   assign w_pending = (r_state == PEND_HI) ? r_run : r_hold;

   always_ff @(posedge clk) begin
      if (!reset && w_glitch) begin
         $display("at time %7.3f, glitch on <%m> width %0d", $realtime, w_pending);
         if (!clear_cnt && r_gcnt != '1 && w_gcnt_nxt == '1)
            $display("warning: glitch counter saturated on <%m>");
      end
   end
`else
   // Pure logic build: no simulation output.
`endif

   assign filt_out   = r_filt;
   assign rise_evt   = r_rise;
   assign fall_evt   = r_fall;
   assign glitch     = r_glitch;
   assign width      = r_width;
   assign width_vld  = r_wvld;
   assign glitch_cnt = r_gcnt;

endmodule

// File: tb/tb_prsim_pulse_monitor.sv
// Self-checking bench: two monitors (default and MIN_WIDTH=1/SYNC_STAGES=3) against a sample-history model.
module tb_prsim_pulse_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset     = 1'b1;
   logic sig_in    = 1'b1;
   logic clear_cnt = 1'b0;

   logic [1:0]  dFilt, dRise, dFall, dGl, dWv;
   logic [15:0] dWidth, dGcnt;

   prsim_pulse_monitor #(.SYNC_STAGES(2), .MIN_WIDTH(4), .CNT_W(8)) dutA (
      .clk(clk), .reset(reset), .sig_in(sig_in), .clear_cnt(clear_cnt),
      .filt_out(dFilt[0]), .rise_evt(dRise[0]), .fall_evt(dFall[0]), .glitch(dGl[0]),
      .width(dWidth[7:0]), .width_vld(dWv[0]), .glitch_cnt(dGcnt[7:0])
   );

   prsim_pulse_monitor #(.SYNC_STAGES(3), .MIN_WIDTH(1), .CNT_W(8)) dutB (
      .clk(clk), .reset(reset), .sig_in(sig_in), .clear_cnt(clear_cnt),
      .filt_out(dFilt[1]), .rise_evt(dRise[1]), .fall_evt(dFall[1]), .glitch(dGl[1]),
      .width(dWidth[15:8]), .width_vld(dWv[1]), .glitch_cnt(dGcnt[15:8])
   );

   int errors = 0;
   int checks = 0;

   // Model: per instance, a delayed copy of sig_in and a streak count of samples
   // disagreeing with the accepted level.
   int syncN[2] = '{2, 3};
   int minW[2]  = '{4, 1};
   int dl[2][4];
   int lvl[2], streak[2], nIdx[2], riseStart[2];
   int eFilt[2], eRise[2], eFall[2], eGl[2], eWv[2], eWidth[2], eGcnt[2];
   bit started = 1'b0;

   int riseSeen[2] = '{0, 0};
   int fallSeen[2] = '{0, 0};
   int glSeen[2]   = '{0, 0};
   int lastWidth[2] = '{-1, -1};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic modelStep(input int i);
      int x;
      if (reset) begin
         for (int k = 0; k < 4; k++) dl[i][k] = 0;
         lvl[i] = 0; streak[i] = 0; nIdx[i] = 0; riseStart[i] = 0;
         eFilt[i] = 0; eRise[i] = 0; eFall[i] = 0; eGl[i] = 0; eWv[i] = 0;
         eWidth[i] = 0; eGcnt[i] = 0;
      end else begin
         x = dl[i][syncN[i]-1];
         for (int k = 3; k > 0; k--) dl[i][k] = dl[i][k-1];
         dl[i][0] = int'(sig_in);
         nIdx[i]++;
         eRise[i] = 0; eFall[i] = 0; eGl[i] = 0; eWv[i] = 0;
         if (x != lvl[i]) begin
            streak[i]++;
            if (streak[i] == minW[i]) begin
               if (lvl[i] == 0) begin
                  lvl[i] = 1; eRise[i] = 1;
                  riseStart[i] = nIdx[i] - minW[i] + 1;
               end else begin
                  lvl[i] = 0; eFall[i] = 1; eWv[i] = 1;
                  eWidth[i] = nIdx[i] - minW[i] + 1 - riseStart[i];
                  if (eWidth[i] > 255) eWidth[i] = 255;
               end
               streak[i] = 0;
            end
         end else if (streak[i] > 0) begin
            eGl[i] = 1;
            streak[i] = 0;
         end
         eFilt[i] = lvl[i];
         if (clear_cnt) eGcnt[i] = 0;
         else if (eGl[i] == 1 && eGcnt[i] < 255) eGcnt[i]++;
      end
   endtask

   initial forever begin
      @(posedge clk);
      modelStep(0);
      modelStep(1);
      started = 1'b1;
   end

   initial forever begin
      @(negedge clk);
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("filt_out[%0d]", i), 32'(dFilt[i]), eFilt[i]);
            checkOutput($sformatf("rise_evt[%0d]", i), 32'(dRise[i]), eRise[i]);
            checkOutput($sformatf("fall_evt[%0d]", i), 32'(dFall[i]), eFall[i]);
            checkOutput($sformatf("glitch[%0d]", i), 32'(dGl[i]), eGl[i]);
            checkOutput($sformatf("width_vld[%0d]", i), 32'(dWv[i]), eWv[i]);
            checkOutput($sformatf("width[%0d]", i), 32'(dWidth[i*8 +: 8]), eWidth[i]);
            checkOutput($sformatf("glitch_cnt[%0d]", i), 32'(dGcnt[i*8 +: 8]), eGcnt[i]);
            if (dRise[i] === 1'b1) riseSeen[i]++;
            if (dFall[i] === 1'b1) fallSeen[i]++;
            if (dGl[i] === 1'b1) glSeen[i]++;
            if (dWv[i] === 1'b1) lastWidth[i] = int'(dWidth[i*8 +: 8]);
         end
      end
   end

   task automatic applyStimulus(input bit v, input int n);
      sig_in = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int latA, latB, r0, f0, g0;

      // Reset held for 3 cycles with sig_in high.
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("reset filt_out", 32'(dFilt[0]), 0);
      checkOutput("reset glitch_cnt", 32'(dGcnt[7:0]), 0);
      checkOutput("reset events", 32'(dRise | dFall | dGl | dWv), 0);

      reset = 1'b0;
      latA = -1;
      latB = -1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (dRise[0] === 1'b1 && latA < 0) latA = k;
         if (dRise[1] === 1'b1 && latB < 0) latB = k;
      end
      checkOutput("rise latency A", latA, 5);
      checkOutput("rise latency B", latB, 3);
      applyStimulus(1'b0, 12);

      // Clean 20-cycle pulse.
      r0 = riseSeen[0]; f0 = fallSeen[0]; g0 = glSeen[0];
      applyStimulus(1'b1, 20);
      applyStimulus(1'b0, 12);
      checkOutput("pulse20 rises", riseSeen[0] - r0, 1);
      checkOutput("pulse20 falls", fallSeen[0] - f0, 1);
      checkOutput("pulse20 glitches", glSeen[0] - g0, 0);
      checkOutput("pulse20 width A", lastWidth[0], 20);
      checkOutput("pulse20 width B", lastWidth[1], 20);

      // Short 2-cycle pulse is rejected.
      r0 = riseSeen[0]; g0 = glSeen[0];
      applyStimulus(1'b1, 2);
      applyStimulus(1'b0, 12);
      checkOutput("short pulse glitches", glSeen[0] - g0, 1);
      checkOutput("short pulse glitch_cnt", 32'(dGcnt[7:0]), 1);
      checkOutput("short pulse rises", riseSeen[0] - r0, 0);
      checkOutput("short pulse filt_out", 32'(dFilt[0]), 0);

      // Dropout inside an accepted high pulse.
      f0 = fallSeen[0]; g0 = glSeen[0];
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 12);
      checkOutput("dropout glitches", glSeen[0] - g0, 1);
      checkOutput("dropout falls", fallSeen[0] - f0, 1);
      checkOutput("dropout width", lastWidth[0], 22);

      // Reset in the middle of a pending pulse.
      applyStimulus(1'b1, 4);
      reset = 1'b1;
      applyStimulus(1'b1, 1);
      reset = 1'b0;
      applyStimulus(1'b0, 12);
      checkOutput("mid reset glitch_cnt", 32'(dGcnt[7:0]), 0);

      // Saturation, clear, and clear coincident with a glitch.
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'b1, 2);
         applyStimulus(1'b0, 2);
      end
      applyStimulus(1'b0, 6);
      checkOutput("saturated glitch_cnt", 32'(dGcnt[7:0]), 255);
      clear_cnt = 1'b1;
      applyStimulus(1'b0, 1);
      clear_cnt = 1'b0;
      checkOutput("cleared glitch_cnt", 32'(dGcnt[7:0]), 0);
      applyStimulus(1'b1, 2);
      applyStimulus(1'b0, 6);
      checkOutput("single glitch_cnt", 32'(dGcnt[7:0]), 1);
      applyStimulus(1'b1, 2);
      applyStimulus(1'b0, 2);
      clear_cnt = 1'b1;
      applyStimulus(1'b0, 1);
      clear_cnt = 1'b0;
      checkOutput("coincident glitch pulse", 32'(dGl[0]), 1);
      checkOutput("coincident glitch_cnt", 32'(dGcnt[7:0]), 0);
      checkOutput("B never glitches", glSeen[1], 0);

      applyStimulus(1'b0, 4);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prsim_pulse_monitor.md
Name: prsim_pulse_monitor

Overview:
- Downstream consumer of a signal returned from the prsim co-simulation, for example the out0 net produced by the inverter chain.
- Synchronises the asynchronous net into the clk domain and debounces it with a minimum-width filter.
- Reports accepted edges, measured pulse widths and rejected glitches, so that deliberate instability injected upstream is counted and checked instead of propagating.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on sig_in; legal values 2..4.
- MIN_WIDTH, 4: synchronised cycles a new level must hold before it is accepted; legal values 1..2^CNT_W-1.
- CNT_W, 8: width of the run-length counter, the width output and the glitch counter.

Ports:
- clk  input  1  sampling clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  asynchronous net from prsim ($from_prsim target).
- clear_cnt  input  1  synchronous clear of glitch_cnt.
- filt_out  output  1  debounced level.
- rise_evt  output  1  1-cycle pulse when a rising level is accepted.
- fall_evt  output  1  1-cycle pulse when a falling level is accepted.
- glitch  output  1  1-cycle pulse when a pending level is rejected.
- width  output  CNT_W  high-time of the last accepted high pulse, in cycles.
- width_vld  output  1  1-cycle pulse, coincident with fall_evt, when width updates.
- glitch_cnt  output  CNT_W  saturating count of rejected pulses.

Behaviour:
- Reset (clk with reset=1):
  - synchroniser flops = 0, state = ST_LO, run counter = 0.
  - filt_out = 0, width = 0, glitch_cnt = 0.
  - rise_evt, fall_evt, glitch and width_vld = 0.
  - Reset mid-pulse discards all pending state; no event is emitted on that cycle.
- Synchroniser: s = last stage of the SYNC_STAGES-deep chain. Latency from a sig_in edge to s is SYNC_STAGES cycles.
- FSM states are ST_LO, PEND_HI, ST_HI, PEND_LO.
- ST_LO:
  - s=1 -> PEND_HI, run = 1.
  - Special case MIN_WIDTH=1: go directly to ST_HI, assert rise_evt and set filt_out=1 on the same clock edge.
- PEND_HI:
  - s=1 -> run++. When run+1 reaches MIN_WIDTH -> ST_HI, filt_out=1, rise_evt=1.
  - s=0 -> glitch=1, glitch_cnt++, return to ST_LO.
- ST_HI:
  - s=1 -> run++, saturating at 2^CNT_W-1.
  - s=0 -> PEND_LO, hold = 1. run is frozen and remembered.
- PEND_LO, on each clock:
  - s=0 -> hold++. When hold reaches MIN_WIDTH -> ST_LO, filt_out=0, fall_evt=1, width_vld=1, width = run. run = 0 on the next cycle.
  - s=1 -> glitch=1, glitch_cnt++, return to ST_HI. run continues, adding the hold cycles with saturation.
- Total filter latency: sig_in edge to rise_evt/fall_evt = SYNC_STAGES + MIN_WIDTH - 1 cycles.
- glitch_cnt:
  - saturates at all-ones and never wraps.
  - clear_cnt=1 zeroes it. If a glitch occurs on the same cycle, the clear wins and the result is 0.
- Event pulses:
  - rise_evt, fall_evt and glitch are mutually exclusive.
  - Each is registered, high for exactly one cycle.

Optional Feature:
- PRSIM_MON_GLITCH_DISPLAY_EN defined:
  - On each glitch pulse, print "at time %7.3f, glitch on <%m> width %0d" using $realtime and the pending count.
  - On glitch_cnt saturation, print one warning.
- Undefined: no display or system tasks; the RTL is pure synthesizable logic and the ports are identical.

Decomposition:
- Package prsim_mon_pkg:
  - state encoding localparams ST_LO=2'd0, PEND_HI=2'd1, ST_HI=2'd2, PEND_LO=2'd3.
  - saturating-increment function sat_inc(value, width).
- Sub-module bit_synchronizer (parameter STAGES, ports clk/reset/d/q) holds the flop chain, reset to 0.
- The FSM, counters and outputs stay in prsim_pulse_monitor.

Test Plan:
1. Reset asserted 3 cycles, sig_in=1 throughout -> filt_out=0, glitch_cnt=0, no events. After release, rise_evt at cycle 2+4-1=5.
2. sig_in high for 20 cycles then low (defaults) -> rise_evt once, then fall_evt with width_vld=1 and width=20. glitch never asserts.
3. 2-cycle high pulse, echoing the 5 ps upstream instability -> glitch=1 once, glitch_cnt=1, filt_out stays 0.
4. Filter held high, sig_in drops for 2 cycles then returns -> glitch=1, filt_out stays 1. The eventual width includes the dropout: 10+2+10=22.
5. 300 short glitches with CNT_W=8 -> glitch_cnt saturates at 255. A clear_cnt pulse then gives 0. Clear coincident with a glitch gives 0.
6. MIN_WIDTH=1, SYNC_STAGES=3 -> each sig_in edge yields rise_evt/fall_evt 3 cycles later. No glitches ever occur.
